// File: rtl/zeroriscy_defines.sv
// Encodings shared across the zero-riscy execute stage.
package zeroriscy_defines;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

endpackage

// File: rtl/zeroriscy_md_seq.sv
// Sequential 32-bit multiply/divide unit: one shift-add or restoring-divide step per cycle,
// both sharing a single 33-bit adder, with signs applied to the magnitudes at the end.
module zeroriscy_md_seq
    import zeroriscy_defines::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_en_i,
    input  logic [1:0]  md_op_i,
    input  logic        signed_a_i,
    input  logic        signed_b_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        ready_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        MD_IDLE   = 2'b00,
        MD_CALC   = 2'b01,
        MD_FINISH = 2'b10
    } md_state_e;

    md_state_e   state_q, state_d;
    md_op_e      op_q, op_d;
    logic        neg_q, neg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] result_q, result_d;

    md_op_e      op_in;
    logic        div_in, div_q;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;

    logic [32:0] add_x, add_y;
    logic        add_cin;
    logic [33:0] add_res;

    logic [31:0] iter_hi, iter_lo;
    logic [63:0] prod, prod_s;
    logic [31:0] final_res;

    assign op_in  = md_op_e'(md_op_i);
    assign div_in = (op_in == MD_OP_DIV) || (op_in == MD_OP_REM);
    assign div_q  = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);

    // Division is signed only when both operands are; multiplication honours each flag alone.
    assign sign_a = signed_a_i & op_a_i[31] & (~div_in | signed_b_i);
    assign sign_b = signed_b_i & op_b_i[31] & (~div_in | signed_a_i);
    assign mag_a  = sign_a ? (32'd0 - op_a_i) : op_a_i;
    assign mag_b  = sign_b ? (32'd0 - op_b_i) : op_b_i;

    // Shared adder: MUL adds the multiplicand into the upper half, DIV does a trial
    // subtract of the divisor (carry out set means no borrow, i.e. quotient bit 1).
    always_comb begin
        if (div_q) begin
            add_x   = {acc_hi_q, acc_lo_q[31]};
            add_y   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, acc_hi_q};
            add_y   = acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0;
            add_cin = 1'b0;
        end
    end

    assign add_res = {1'b0, add_x} + {1'b0, add_y} + {33'd0, add_cin};

    always_comb begin
        if (div_q) begin
            iter_hi = add_res[33] ? add_res[31:0] : add_x[31:0];
            iter_lo = {acc_lo_q[30:0], add_res[33]};
        end else begin
            iter_hi = add_res[32:1];
            iter_lo = {add_res[0], acc_lo_q[31:1]};
        end
    end

    always_comb begin
        prod   = {iter_hi, iter_lo};
        prod_s = neg_q ? (64'd0 - prod) : prod;
        case (op_q)
            MD_OP_MULL: final_res = prod_s[31:0];
            MD_OP_MULH: final_res = prod_s[63:32];
            MD_OP_DIV:  final_res = neg_q ? (32'd0 - iter_lo) : iter_lo;
            default:    final_res = neg_q ? (32'd0 - iter_hi) : iter_hi;
        endcase
    end

    always_comb begin
        // NOTE: every _d takes its _q value first so no path can leave it unassigned (no latch).
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;

        case (state_q)
            MD_IDLE: begin
                if (md_en_i && !kill_i) begin
                    op_d     = op_in;
                    cnt_d    = 5'd31;
                    acc_hi_d = 32'd0;
                    if (div_in) begin
                        neg_d    = (op_in == MD_OP_REM) ? sign_a : (sign_a ^ sign_b);
                        opnd_d   = mag_b;
                        acc_lo_d = mag_a;
                        if (op_b_i == 32'd0) begin
                            state_d  = MD_FINISH;
                            result_d = (op_in == MD_OP_DIV) ? 32'hFFFF_FFFF : op_a_i;
                        end else begin
                            state_d = MD_CALC;
                        end
                    end else begin
                        neg_d    = sign_a ^ sign_b;
                        opnd_d   = mag_a;
                        acc_lo_d = mag_b;
                        state_d  = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (kill_i) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_hi_d = iter_hi;
                    acc_lo_d = iter_lo;
                    cnt_d    = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_d  = MD_FINISH;
                        result_d = final_res;
                    end
                end
            end
            MD_FINISH: state_d = MD_IDLE;
            default:   state_d = MD_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            op_q     <= MD_OP_MULL;
            neg_q    <= 1'b0;
            cnt_q    <= 5'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            opnd_q   <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q != MD_IDLE);
    assign ready_o  = (state_q == MD_FINISH);
    assign result_o = result_q;

endmodule
